// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch-stage next-PC sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StMdWait = 2'd2,
        StHalt   = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        NpcSeq  = 2'd0,
        NpcJump = 2'd1,
        NpcBr   = 2'd2,
        NpcJr   = 2'd3
    } npc_sel_e;

    localparam int unsigned MdMaxCyclesDefault = 40;
    localparam int unsigned CntWDefault        = 6;

endpackage

// File: rtl/pc_sequencer_md_stall_counter.sv
// Loadable saturating cycle counter for the multdiv stall, with a done flag at MAX_COUNT.
module md_stall_counter
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MdMaxCyclesDefault,
    parameter int unsigned CNT_W     = CntWDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic run_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_d, count_q;

    // Anything other than load or run clears, so each wait starts from a clean count.
    always_comb begin
        count_d = '0;
        if (load_i) begin
            count_d = CNT_W'(1);
        end else if (run_i) begin
            count_d = (count_q == MaxCnt) ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == MaxCnt);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC select, PC enable and pipeline flush/stall strobes for the fetch stage.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned MD_MAX_CYCLES = MdMaxCyclesDefault,
    parameter int unsigned CNT_W         = CntWDefault
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_plus_4,
    input  logic [4:0]  pc_upper_5,
    input  logic        jump_d,
    input  logic [26:0] jump_target_d,
    input  logic        branch_taken_x,
    input  logic [31:0] branch_target_x,
    input  logic        jr_x,
    input  logic [31:0] jr_target_x,
    input  logic        hazard_stall,
    input  logic        md_start,
    input  logic        md_ready,
    input  logic        halt_d,
    output logic [31:0] pc_in,
    output logic        pc_ena,
    output logic        flush_fd,
    output logic        flush_dx,
    output logic        stall_fd,
    output logic        halted
);

    seq_state_e state_d, state_q;
    npc_sel_e   npc_sel;
    logic       x_redirect;
    logic       md_done;
    logic       md_release;
    logic       md_enter;
    logic       md_run;
    logic       d_free;

    assign x_redirect = jr_x | branch_taken_x;
    assign md_release = md_ready | md_done;

    md_stall_counter #(
        .MAX_COUNT(MD_MAX_CYCLES),
        .CNT_W    (CNT_W)
    ) u_md_cnt (
        .clk_i (clock),
        .rst_ni(reset),
        .load_i(md_enter),
        .run_i (md_run),
        .done_o(md_done)
    );

    always_comb begin
        state_d  = state_q;
        npc_sel  = NpcSeq;
        pc_ena   = 1'b0;
        flush_fd = 1'b0;
        flush_dx = 1'b0;
        stall_fd = 1'b0;
        halted   = 1'b0;
        md_enter = 1'b0;
        md_run   = 1'b0;
        d_free   = 1'b0;

        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                d_free   = 1'b1;
                md_enter = md_start & ~md_ready;
                if (md_enter) state_d = StMdWait;
            end
            StMdWait: begin
                if (md_release) begin
                    d_free  = 1'b1;
                    state_d = StRun;
                end else begin
                    md_run = 1'b1;
                end
            end
            StHalt: begin
                halted   = 1'b1;
                flush_fd = 1'b1;
            end
        endcase

        // X redirect kills younger work but never releases or cancels an older multdiv wait.
        if (x_redirect && (state_q == StRun || state_q == StMdWait)) begin
            npc_sel  = jr_x ? NpcJr : NpcBr;
            pc_ena   = 1'b1;
            flush_fd = 1'b1;
            flush_dx = 1'b1;
        end else if (d_free) begin
            if (hazard_stall) begin
                stall_fd = 1'b1;
                flush_dx = 1'b1;
            end else if (halt_d) begin
                // A halt meeting a new multdiv wait stays parked in D until the wait ends.
                if (md_enter) begin
                    stall_fd = 1'b1;
                end else begin
                    flush_fd = 1'b1;
                    state_d  = StHalt;
                end
            end else if (jump_d) begin
                npc_sel  = NpcJump;
                pc_ena   = 1'b1;
                flush_fd = 1'b1;
            end else begin
                pc_ena = 1'b1;
            end
        end else if (state_q == StMdWait) begin
            stall_fd = 1'b1;
        end
    end

    always_comb begin
        pc_in = pc_plus_4;
        unique case (npc_sel)
            NpcSeq:  pc_in = pc_plus_4;
            NpcJump: pc_in = {pc_upper_5, jump_target_d};
            NpcBr:   pc_in = branch_target_x;
            NpcJr:   pc_in = jr_target_x;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a small PC register model.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] pc_plus_4;
    logic [4:0]  pc_upper_5;
    logic        jump_d;
    logic [26:0] jump_target_d;
    logic        branch_taken_x;
    logic [31:0] branch_target_x;
    logic        jr_x;
    logic [31:0] jr_target_x;
    logic        hazard_stall;
    logic        md_start;
    logic        md_ready;
    logic        halt_d;
    logic [31:0] pc_in;
    logic        pc_ena;
    logic        flush_fd;
    logic        flush_dx;
    logic        stall_fd;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;
    int stall;
    int bad;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .pc_plus_4      (pc_plus_4),
        .pc_upper_5     (pc_upper_5),
        .jump_d         (jump_d),
        .jump_target_d  (jump_target_d),
        .branch_taken_x (branch_taken_x),
        .branch_target_x(branch_target_x),
        .jr_x           (jr_x),
        .jr_target_x    (jr_target_x),
        .hazard_stall   (hazard_stall),
        .md_start       (md_start),
        .md_ready       (md_ready),
        .halt_d         (halt_d),
        .pc_in          (pc_in),
        .pc_ena         (pc_ena),
        .flush_fd       (flush_fd),
        .flush_dx       (flush_dx),
        .stall_fd       (stall_fd),
        .halted         (halted)
    );

    // PC register fed by the sequencer.
    always @(posedge clock or negedge reset) begin
        if (!reset) pc_q <= 32'h0;
        else if (pc_ena) pc_q <= pc_in;
    end
    assign pc_plus_4 = pc_q + 32'd4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        pc_upper_5      = 5'd0;
        jump_d          = 1'b0;
        jump_target_d   = 27'd0;
        branch_taken_x  = 1'b0;
        branch_target_x = 32'd0;
        jr_x            = 1'b0;
        jr_target_x     = 32'd0;
        hazard_stall    = 1'b0;
        md_start        = 1'b0;
        md_ready        = 1'b0;
        halt_d          = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clock);
        #1;
        check_eq("in_reset_ena", 32'(pc_ena), 32'd0);
        check_eq("in_reset_flush", 32'({flush_fd, flush_dx, stall_fd, halted}), 32'd0);
        check_eq("in_reset_pc_in", pc_in, 32'h4);

        // Release reset: one BOOT cycle, then sequential fetch.
        reset = 1'b1;
        #1;
        check_eq("boot_ena", 32'(pc_ena), 32'd0);
        check_eq("boot_strobes", 32'({flush_fd, flush_dx, stall_fd}), 32'd0);
        @(negedge clock); #1;
        check_eq("run_ena", 32'(pc_ena), 32'd1);
        check_eq("run_pc_4", pc_in, 32'h4);
        @(negedge clock); #1;
        check_eq("run_pc_8", pc_in, 32'h8);
        @(negedge clock); #1;
        check_eq("run_pc_c", pc_in, 32'hC);

        // D jump.
        @(negedge clock);
        jump_d = 1'b1; pc_upper_5 = 5'b00001; jump_target_d = 27'h40;
        #1;
        check_eq("jump_pc_in", pc_in, 32'h0800_0040);
        check_eq("jump_strobes", 32'({pc_ena, flush_fd, flush_dx, stall_fd}), 32'b1100);
        @(negedge clock);
        clr_inputs();
        #1;
        check_eq("after_jump_pc", pc_in, 32'h0800_0044);

        // Branch beats jump and hazard.
        @(negedge clock);
        branch_taken_x = 1'b1; branch_target_x = 32'h100; jump_d = 1'b1; hazard_stall = 1'b1;
        jump_target_d = 27'h77;
        #1;
        check_eq("br_combo_pc_in", pc_in, 32'h100);
        check_eq("br_combo_strobes", 32'({pc_ena, flush_fd, flush_dx, stall_fd}), 32'b1110);

        // jr beats branch.
        @(negedge clock);
        clr_inputs();
        jr_x = 1'b1; jr_target_x = 32'h200; branch_taken_x = 1'b1; branch_target_x = 32'h300;
        #1;
        check_eq("jr_prio_pc_in", pc_in, 32'h200);

        // Hazard stall holds D and ignores the jump there.
        @(negedge clock);
        clr_inputs();
        hazard_stall = 1'b1; jump_d = 1'b1; jump_target_d = 27'h55;
        #1;
        check_eq("hazard_strobes", 32'({pc_ena, flush_fd, flush_dx, stall_fd}), 32'b0011);
        check_eq("hazard_pc_in", pc_in, 32'h204);

        // Hazard drops: jump is taken now.
        @(negedge clock);
        hazard_stall = 1'b0;
        #1;
        check_eq("jump_after_hazard", pc_in, 32'h0000_0055);
        @(negedge clock);
        clr_inputs();

        // Multdiv released by md_ready after 17 stalled cycles.
        md_start = 1'b1;
        #1;
        check_eq("md_start_ena", 32'(pc_ena), 32'd1);
        stall = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            md_start = 1'b0;
            md_ready = (i == 18);
            #1;
            if (i == 1) check_eq("md_wait_strobes", 32'({pc_ena, flush_dx, stall_fd}), 32'b001);
            if (pc_ena) break;
            stall++;
        end
        check_eq("md_ready_stall_len", 32'(stall), 32'd17);
        @(negedge clock);
        md_ready = 1'b0;
        #1;
        check_eq("md_after_release", 32'({pc_ena, stall_fd}), 32'b10);

        // Redirect while waiting: taken, but the wait continues.
        md_start = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clock);
            md_start = 1'b0;
        end
        @(negedge clock);
        branch_taken_x = 1'b1; branch_target_x = 32'h400;
        #1;
        check_eq("md_redirect_pc_in", pc_in, 32'h400);
        check_eq("md_redirect_strobes", 32'({pc_ena, flush_fd, flush_dx}), 32'b111);
        @(negedge clock);
        clr_inputs();
        #1;
        check_eq("md_redirect_still_stalled", 32'(pc_ena), 32'd0);
        check_eq("md_redirect_state", 32'(dut.state_q), 32'(StMdWait));
        @(negedge clock);
        md_ready = 1'b1;
        #1;
        check_eq("md_redirect_release_pc", pc_in, 32'h404);
        check_eq("md_redirect_release_ena", 32'(pc_ena), 32'd1);

        // md_start with md_ready already high: no stall.
        @(negedge clock);
        md_start = 1'b1; md_ready = 1'b1;
        #1;
        check_eq("md_fast_ena", 32'(pc_ena), 32'd1);
        @(negedge clock);
        clr_inputs();
        #1;
        check_eq("md_fast_next_ena", 32'(pc_ena), 32'd1);

        // Timeout: counter is 1 in the first wait cycle and releases on the 40th.
        @(negedge clock);
        md_start = 1'b1;
        stall = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            md_start = 1'b0;
            #1;
            if (pc_ena) break;
            stall++;
        end
        check_eq("md_timeout_stall_len", 32'(stall), 32'd39);
        @(negedge clock); #1;
        check_eq("md_timeout_state", 32'(dut.state_q), 32'(StRun));

        // Branch together with md_start: redirect and enter the wait.
        @(negedge clock);
        md_start = 1'b1; branch_taken_x = 1'b1; branch_target_x = 32'h800;
        #1;
        check_eq("md_br_pc_in", pc_in, 32'h800);
        check_eq("md_br_strobes", 32'({pc_ena, flush_fd, flush_dx}), 32'b111);
        @(negedge clock);
        clr_inputs();
        #1;
        check_eq("md_br_state", 32'(dut.state_q), 32'(StMdWait));

        // Reset in the 5th wait cycle.
        for (int i = 2; i <= 5; i++) @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_eq("md_reset_state", 32'(dut.state_q), 32'(StBoot));
        check_eq("md_reset_count", 32'(dut.u_md_cnt.count_q), 32'd0);
        check_eq("md_reset_ena", 32'(pc_ena), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("md_reset_boot_ena", 32'(pc_ena), 32'd0);
        @(negedge clock); #1;
        check_eq("md_reset_run", 32'({pc_ena, stall_fd}), 32'b10);
        check_eq("md_reset_run_pc", pc_in, 32'h4);

        // Halt.
        @(negedge clock);
        halt_d = 1'b1;
        #1;
        check_eq("halt_entry", 32'({pc_ena, flush_fd, halted}), 32'b010);
        @(negedge clock);
        halt_d = 1'b0;
        #1;
        check_eq("halt_pc_in", pc_in, pc_q + 32'd4);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!halted || pc_ena || !flush_fd) bad++;
            @(negedge clock);
            branch_taken_x = (i == 10);
            #1;
        end
        clr_inputs();
        check_eq("halt_hold_bad_cycles", 32'(bad), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("halt_reset_halted", 32'({halted, flush_fd, pc_ena}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("halt_reset_boot_ena", 32'(pc_ena), 32'd0);
        @(negedge clock); #1;
        check_eq("halt_reset_run_ena", 32'(pc_ena), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the fetch stage. Each cycle it selects the value presented to the PC register's `pc_in`, and drives the PC register's enable. It also generates the pipeline flush strobes for redirects and stalls fetch for load-use hazards, multiply/divide latency and halt. It sits beside the PC/imem-address block and consumes that block's `pc_plus_4` and `pc_upper_5` outputs.

## Interface
Parameters:
- `MD_MAX_CYCLES`, 40: upper bound on multdiv stall; the stall is forced released at this count.
- `CNT_W`, 6: width of the multdiv cycle counter; must satisfy 2^CNT_W > MD_MAX_CYCLES.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state is cleared while low.
- `pc_plus_4` in 32: PC+4 from the PC block.
- `pc_upper_5` in 5: PC[31:27] from the PC block.
- `jump_d` in 1: j/jal decoded in D.
- `jump_target_d` in 27: T field of that jump.
- `branch_taken_x` in 1: branch resolved taken in X.
- `branch_target_x` in 32: its target.
- `jr_x` in 1: jr in X.
- `jr_target_x` in 32: register value for jr.
- `hazard_stall` in 1: load-use stall request from the hazard unit.
- `md_start` in 1: multdiv op entering X (one-cycle pulse).
- `md_ready` in 1: multdiv result valid.
- `halt_d` in 1: halt instruction decoded in D.
- `pc_in` out 32: next PC to the PC register.
- `pc_ena` out 1: PC register enable.
- `flush_fd` out 1: bubble F/D latch.
- `flush_dx` out 1: bubble D/X latch.
- `stall_fd` out 1: hold F/D latch.
- `halted` out 1: sequencer in HALT.

## Operation
- States: BOOT, RUN, MD_WAIT, HALT.
  - Reset enters BOOT.
  - BOOT -> RUN unconditionally after one cycle.
- Redirect priority, highest first:
  1. X redirect (`jr_x`, then `branch_taken_x`; jr wins if both are asserted).
  2. D jump.
  3. Sequential `pc_plus_4`.
- `pc_in` selection:
  - jr: `jr_target_x`.
  - branch: `branch_target_x`.
  - jump: {`pc_upper_5`, `jump_target_d`}, with no shift.
  - otherwise: `pc_plus_4`.
- X redirect:
  - Asserts `pc_ena`, `flush_fd` and `flush_dx` in the same cycle.
  - Overrides `hazard_stall`, `jump_d`, `halt_d` and the MD_WAIT hold, because the instruction being killed is younger.
  - If in MD_WAIT, the state stays MD_WAIT; the multdiv op is older and is not killed.
  - Exception to the above: an X redirect does not release the MD_WAIT stall. Only `md_ready` or the timeout releases it.
- D jump (no X redirect):
  - Asserts `pc_ena` and `flush_fd` only.
  - Ignored while `hazard_stall` or MD_WAIT holds D; it is taken when the hold releases.
- `hazard_stall` (no X redirect): `pc_ena`=0, `stall_fd`=1, `flush_dx`=1.
- RUN -> MD_WAIT:
  - On `md_start` with `md_ready` low. The counter loads 1.
  - In MD_WAIT: `pc_ena`=0, `stall_fd`=1, `flush_dx`=0 (X holds the op); the counter increments each cycle.
- MD_WAIT -> RUN:
  - On `md_ready`=1, or when the counter reaches `MD_MAX_CYCLES`.
  - `pc_ena`=1 resumes in that same cycle.
  - `md_start` with `md_ready` already high in the same cycle stays in RUN with no stall.
- RUN -> HALT:
  - On `halt_d` with no X redirect.
  - That cycle: `pc_ena`=0, `flush_fd`=1.
- HALT:
  - Absorbing: `pc_ena`=0, `halted`=1, and `pc_in` = `pc_plus_4`.
  - `flush_fd` stays at 1.
  - Exit is by reset only.
- BOOT: `pc_ena`=0, all flushes 0 and `stall_fd`=0. This ensures address 0 is held for one full fetch cycle after reset.

## Timing
- All outputs are combinational from the current inputs and the registered state. Zero latency: the redirect target is loaded by the PC register at the next rising edge.
- Registered state: 2-bit FSM state and the `CNT_W` counter.
  - Reset values: state=BOOT, counter=0.
  - While `reset` is low: `pc_ena`=0, `flush_fd`=0, `flush_dx`=0, `stall_fd`=0, `halted`=0, `pc_in`=`pc_plus_4`.
- Reset asserted mid-MD_WAIT or mid-HALT returns to BOOT immediately (asynchronously). The counter clears.
- Counter saturates at `MD_MAX_CYCLES` and never wraps.
- Simultaneous events in one cycle:
  - `branch_taken_x` + `jump_d` + `hazard_stall`: branch taken; both flushes are asserted; `stall_fd`=0.
  - `md_start` + `branch_taken_x`: redirect taken with both flushes, and the state goes to MD_WAIT.

## Structure
- The shared package holds:
  - state encodings: BOOT=0, RUN=1, MD_WAIT=2, HALT=3;
  - next-PC select codes: SEQ, JUMP, BR, JR;
  - the localparam for the default `MD_MAX_CYCLES`.
- One sub-module, `md_stall_counter`: a loadable saturating counter with a done flag at `MD_MAX_CYCLES`.
- The next-PC mux and the FSM stay in `pc_sequencer`.

## Test plan
- Reset release, no events:
  - Cycle 0: `pc_ena`=0 (BOOT).
  - From cycle 1: `pc_ena`=1 and `pc_in` tracks `pc_plus_4` (0x4, 0x8, ...).
- `jump_d`=1, `pc_upper_5`=5'b00001, `jump_target_d`=27'h40 -> `pc_in`=0x08000040, `flush_fd`=1, `flush_dx`=0.
- `branch_taken_x`=1 (target 0x100) together with `jump_d`=1 and `hazard_stall`=1 -> `pc_in`=0x100, `pc_ena`=1, both flushes=1, `stall_fd`=0.
- Multdiv:
  - `md_start` pulse, then `md_ready` after 17 cycles -> `pc_ena`=0 for exactly 17 cycles, then 1.
  - Repeat with `md_ready` never asserted -> release after 40 cycles.
- `halt_d`=1 -> `halted`=1 from the next cycle and `pc_ena` stays 0 for 100 cycles. Pulling `reset` low mid-halt -> `halted`=0 immediately, then the BOOT sequence.
- Reset asserted in cycle 5 of MD_WAIT -> counter=0 and state=BOOT. After release, one BOOT cycle, then normal RUN.
